// File: rtl/buffer1d_unpack_pkg.sv
// Shared constants for the 1-D shift buffer family: default geometry and FSM encoding.
// Module parameters override the geometry defaults; idx_width() sizes the lane index.
package buffer1d_unpack_pkg;

  localparam int BUF_DW    = 12;
  localparam int BUF_TAPS  = 5;
  localparam int BUF_WIN_W = BUF_DW * BUF_TAPS;
  localparam int BUF_IDX_W = $clog2(BUF_TAPS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // A single-tap window still needs a one-bit index to stay a legal vector.
  function automatic int idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/buffer1d_unpack_lane_mux.sv
// Combinational TAPS:1 selection of one DW-bit lane from a packed window.
// Zero latency; no flow control. Out-of-range selects return zero.
module lane_mux #(
  parameter int DW    = 12,
  parameter int TAPS  = 5,
  parameter int IDX_W = 3
) (
  input  logic [DW*TAPS-1:0] win,
  input  logic [IDX_W-1:0]   sel,
  output logic [DW-1:0]      lane
);

  always_comb begin
    lane = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (sel == IDX_W'(k)) lane = win[k*DW +: DW];
    end
  end

endmodule

// File: rtl/buffer1d_unpack.sv
// Parallel-in/serial-out window unpacker: one window load, then TAPS samples, first one the cycle after load.
// Stalls indefinitely on out_ready=0; accepts the next window on the final beat so windows stream gap-free.
module buffer1d_unpack
  import buffer1d_unpack_pkg::*;
#(
  parameter int DW        = BUF_DW,
  parameter int TAPS      = BUF_TAPS,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DW*TAPS-1:0] d_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW-1:0]     d_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int               IDX_W    = idx_width(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  logic [0:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   sel;
  logic [DW*TAPS-1:0] hold;
  logic               at_last;
  logic               load;
  logic               beat;

  assign at_last   = (idx == LAST_IDX);
  assign busy      = (state == SEND);
  assign out_valid = busy;
  assign out_last  = busy & at_last;

  // The final beat frees the holding register, so a new window may land on the same edge.
  assign in_ready  = en & ~rst & ((state == IDLE) | (out_ready & at_last));

  assign load = en & in_valid & in_ready;
  assign beat = en & out_valid & out_ready;
  assign sel  = MSB_FIRST ? (LAST_IDX - idx) : idx;

  lane_mux #(
    .DW    (DW),
    .TAPS  (TAPS),
    .IDX_W (IDX_W)
  ) u_lane_mux (
    .win  (hold),
    .sel  (sel),
    .lane (d_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            hold  <= d_in;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (beat) begin
            if (!at_last) begin
              idx <= idx + 1'b1;
            end else if (load) begin
              hold <= d_in;
              idx  <= '0;
            end else begin
              idx   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer1d_unpack.sv
// Scoreboard bench for buffer1d_unpack: LSB-first and MSB-first instances share all stimulus.
module tb_buffer1d_unpack;

  localparam int DW   = 12;
  localparam int TAPS = 5;
  localparam int WW   = DW * TAPS;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [WW-1:0] d_in = '0;

  logic          in_ready, f_valid, f_last, f_busy;
  logic [DW-1:0] f_dout;
  logic          r_in_ready, r_valid, r_last, r_busy;
  logic [DW-1:0] r_dout;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q_f[$];
  exp_t q_r[$];
  int   beat_cyc[$];

  buffer1d_unpack #(.DW(DW), .TAPS(TAPS), .MSB_FIRST(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
    .d_out(f_dout), .out_valid(f_valid), .out_ready(out_ready), .out_last(f_last), .busy(f_busy)
  );

  buffer1d_unpack #(.DW(DW), .TAPS(TAPS), .MSB_FIRST(1'b1)) u_rev (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .in_valid(in_valid), .in_ready(r_in_ready),
    .d_out(r_dout), .out_valid(r_valid), .out_ready(out_ready), .out_last(r_last), .busy(r_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] mk(input int a, input int b, input int c, input int d, input int e);
    logic [WW-1:0] w;
    w = {e[DW-1:0], d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    return w;
  endfunction

  task automatic push_win(input logic [WW-1:0] w);
    exp_t e;
    for (int k = 0; k < TAPS; k++) begin
      e.d = w[k*DW +: DW];
      e.last = (k == TAPS - 1);
      q_f.push_back(e);
      e.d = w[(TAPS-1-k)*DW +: DW];
      q_r.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the loading edge.
  task automatic load(input logic [WW-1:0] w, output int waited);
    in_valid = 1'b1;
    d_in = w;
    waited = 0;
    forever begin
      @(negedge clk);
      if (en && in_ready) break;
      waited++;
      if (waited > 60) begin
        chk("load_timeout", waited, 0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    push_win(w);
    #1;
    in_valid = 1'b0;
    chk("load_latency_valid", int'(f_valid), 1);
    chk("load_latency_busy", int'(f_busy), 1);
    chk("post_load_in_ready", int'(in_ready), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q_f.size() != 0 || q_r.size() != 0); i++) @(negedge clk);
    if (q_f.size() != 0 || q_r.size() != 0) chk("drain_timeout", q_f.size() + q_r.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && en && out_ready && f_valid) begin
      if (q_f.size() == 0) chk("fwd_unexpected_beat", 1, 0);
      else begin
        e = q_f.pop_front();
        chk("fwd_dout", int'(f_dout), int'(e.d));
        chk("fwd_last", int'(f_last), int'(e.last));
      end
      beat_cyc.push_back(cyc);
    end
    if (!rst && en && out_ready && r_valid) begin
      if (q_r.size() == 0) chk("rev_unexpected_beat", 1, 0);
      else begin
        e = q_r.pop_front();
        chk("rev_dout", int'(r_dout), int'(e.d));
        chk("rev_last", int'(r_last), int'(e.last));
      end
    end
  end

  initial begin
    int w;
    logic [WW-1:0] w0;
    w0 = mk(0, 1, 2, 3, 4);

    // reset state
    #2;
    chk("rst_out_valid", int'(f_valid), 0);
    chk("rst_out_last", int'(f_last), 0);
    chk("rst_busy", int'(f_busy), 0);
    chk("rst_dout", int'(f_dout), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_rev_busy", int'(r_busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic order
    load(w0, w);
    chk("basic_wait", w, 0);
    drain();
    chk("idle_out_valid", int'(f_valid), 0);
    chk("idle_out_last", int'(f_last), 0);
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_rev_in_ready", int'(r_in_ready), 1);

    // back-to-back windows
    beat_cyc.delete();
    load(w0, w);
    load(mk(5, 6, 7, 8, 9), w);
    chk("b2b_ready_wait", w, 4);
    drain();
    chk("b2b_beats", beat_cyc.size(), 10);
    for (int i = 1; i < beat_cyc.size(); i++) chk("b2b_gap", beat_cyc[i] - beat_cyc[i-1], 1);

    // backpressure at sample 2
    load(w0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_dout", int'(f_dout), 2);
      chk("bp_valid", int'(f_valid), 1);
      chk("bp_rev_dout", int'(r_dout), 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // enable freeze at sample 1 with a competing window offered
    load(w0, w);
    @(posedge clk); #1;
    en = 1'b0;
    in_valid = 1'b1;
    d_in = mk(99, 100, 101, 102, 103);
    repeat (2) begin
      @(negedge clk);
      chk("en_in_ready", int'(in_ready), 0);
      chk("en_dout", int'(f_dout), 1);
      chk("en_valid", int'(f_valid), 1);
    end
    @(posedge clk); #1;
    en = 1'b1;
    in_valid = 1'b0;
    drain();
    chk("en_no_load_idle", int'(f_valid), 0);

    // asynchronous reset at sample 3
    load(w0, w);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_dout", int'(f_dout), 3);
    #2;
    rst = 1'b1;
    q_f.delete();
    q_r.delete();
    #1;
    chk("mid_rst_valid", int'(f_valid), 0);
    chk("mid_rst_last", int'(f_last), 0);
    chk("mid_rst_busy", int'(f_busy), 0);
    chk("mid_rst_dout", int'(f_dout), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    load(mk(10, 11, 12, 13, 14), w);
    drain();

    chk("final_fwd_queue", q_f.size(), 0);
    chk("final_rev_queue", q_r.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer1d_unpack.md
Name: buffer1d_unpack

Overview:
- Parallel-in, serial-out companion to the 1-D shift buffer.
- Accepts a full TAPS-wide window of DW-bit samples in one transfer, then emits the samples one per cycle on a valid/ready stream.
- Used where the convolution path hands a processed window back to a serial sample stream, e.g. writeback or re-feeding the next line buffer.
- Global `en` freezes the block, matching the buffer's enable semantics.

Parameters:
- DW, 12, sample width in bits.
- TAPS, 5, samples per window; input width is DW*TAPS (60 by default).
- MSB_FIRST, 0, emission order. 0: lane 0 (d_in[DW-1:0]) is emitted first. 1: lane TAPS-1 is emitted first.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when 0, all state holds and no transfer occurs on either side.
- d_in  in  DW*TAPS  parallel window; lane k = d_in[k*DW +: DW].
- in_valid  in  1  d_in is valid.
- in_ready  out  1  block can accept a window this cycle.
- d_out  out  DW  current serial sample.
- out_valid  out  1  d_out is valid.
- out_ready  in  1  downstream accepts d_out this cycle.
- out_last  out  1  d_out is the final sample of the current window.
- busy  out  1  a window is held (state SEND).

Behaviour:
- Reset (async, immediate): state=IDLE, idx=0, holding register=0, d_out=0, out_valid=0, out_last=0, busy=0, in_ready=0 while rst is high.
- Transfers:
  - load = en & in_valid & in_ready
  - beat = en & out_valid & out_ready
- FSM states:
  - IDLE: out_valid=0; in_ready=en.
    - On load: capture d_in into the holding register, idx=0, go to SEND.
  - SEND: out_valid=1; d_out = lane(idx) if MSB_FIRST=0, else lane(TAPS-1-idx).
    - out_last = (idx==TAPS-1).
    - On a beat with idx<TAPS-1: idx+1.
    - On a beat with idx==TAPS-1: if a load occurs in the same cycle, capture the new window, idx=0, stay in SEND. Otherwise go to IDLE.
- in_ready in SEND = en & out_ready & (idx==TAPS-1). This is a combinational path from out_ready, and it allows back-to-back windows with no bubble.
- Throughput: TAPS beats per window, sustained.
- Latency: first sample is valid the cycle after load.
- d_out/out_valid/out_last are registered or derived only from registered state; they are stable while out_ready=0.
- Backpressure: with out_ready=0, idx, the holding register and d_out hold indefinitely.
- en=0: no load, no beat. out_valid keeps its registered value, but no transfer counts. in_ready=0.
- in_valid while busy and not on the last beat: ignored. Upstream must hold the data until in_ready.
- Reset mid-window: the window is discarded, the block returns to IDLE, and no partial completion occurs.
- idx width = clog2(TAPS); it never exceeds TAPS-1.

Decomposition:
- Shared package/header (shared with buffer1d): DW, TAPS, the derived WIN_W=DW*TAPS, IDX_W=clog2(TAPS), and the state encoding constants IDLE=0, SEND=1.
- One natural sub-module, `lane_mux`: combinational TAPS:1 selection of a DW slice by index, reused by the window tap logic.
- Otherwise a single module: FSM, index counter, holding register.

Test Plan:
- Basic order:
  - Stimulus: MSB_FIRST=0, out_ready=1, load d_in={12'd4,12'd3,12'd2,12'd1,12'd0}.
  - Required: d_out=0,1,2,3,4 on 5 consecutive cycles starting the cycle after load; out_last only with 4; then out_valid=0, in_ready=1.
- Back-to-back:
  - Stimulus: in_valid held with window {9,8,7,6,5} presented during the last beat of the first window.
  - Required: 10 consecutive samples 0..9 with no gap; in_ready pulses exactly once at the last beat; out_last at samples 4 and 9.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles while d_out=2.
  - Required: d_out stays 2 and out_valid stays 1 for those cycles; the sequence resumes with 3,4; no samples lost or repeated.
- Enable freeze:
  - Stimulus: en=0 for 2 cycles mid-window (d_out=1), with out_ready=1 and in_valid=1.
  - Required: idx does not advance, in_ready=0, no new load; after en=1 the sequence continues 1,2,3,4.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between clock edges) while d_out=3.
  - Required: out_valid, out_last, busy and d_out go to 0 immediately; after release, a new window {10..14} emits 10..14 from the start.
- Reverse order:
  - Stimulus: MSB_FIRST=1, same window as the basic order test.
  - Required: d_out=4,3,2,1,0, with out_last on 0.
